// File: rtl/tc_array_pkg.sv
// Shared constants for the multi-channel timer/counter: FSM encodings,
// operating modes, register offsets and CTRL field positions.
package tc_array_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_CNT  = 2'd2;
    localparam state_t ST_INT  = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_PULSE   = 2'd1;
    localparam logic [1:0] MODE_STICKY  = 2'd2;

    // Register offsets as seen on addr[3:2] within a channel window
    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_PRESET   = 2'd1;
    localparam logic [1:0] OFF_COUNT    = 2'd2;
    localparam logic [1:0] OFF_PRESCALE = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/tc_channel.sv
// One timer channel: configuration storage, prescaler, down-counter and the
// IDLE/LOAD/CNT/INT sequencer.
//
//   state   | meaning
//   IDLE    | stopped, waiting for EN
//   LOAD    | COUNT <- PRESET, prescaler cleared
//   CNT     | counting down, one step per PRESCALE+1 cycles
//   INT     | expired; mode decides reload or stop
module tc_channel
    import tc_array_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_ctrl,
    input  logic [CTRL_W-1:0] ctrl_wdata,
    input  logic              wr_preset,
    input  logic [CNT_W-1:0]  preset_wdata,
    input  logic              wr_prescale,
    input  logic [PRE_W-1:0]  prescale_wdata,
    output logic [CTRL_W-1:0] ctrl,
    output logic [CNT_W-1:0]  preset,
    output logic [CNT_W-1:0]  count,
    output logic [PRE_W-1:0]  prescale,
    output logic              expire,
    output logic              status_clr
);

    state_t           state;
    logic [PRE_W-1:0] psc_cnt;
    logic             en;
    logic [1:0]       mode;

    assign en   = ctrl[CTRL_EN];
    assign mode = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

    assign expire     = (state == ST_CNT) && en && (count == '0);
    assign status_clr = (state == ST_INT) && en && (mode == MODE_PULSE);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= '0;
            prescale <= '0;
            count    <= '0;
            psc_cnt  <= '0;
            state    <= ST_IDLE;
        end else begin
            if (wr_ctrl)     ctrl     <= ctrl_wdata;
            if (wr_preset)   preset   <= preset_wdata;
            if (wr_prescale) prescale <= prescale_wdata;

            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else begin
                        count   <= preset;
                        psc_cnt <= '0;
                        state   <= ST_CNT;
                    end
                end
                ST_CNT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (count == '0) begin
                        state <= ST_INT;
                    end else if (psc_cnt == prescale) begin
                        count   <= count - CNT_W'(1);
                        psc_cnt <= '0;
                    end else begin
                        psc_cnt <= psc_cnt + PRE_W'(1);
                    end
                end
                default: begin
                    // A one-shot clears its own EN, overriding a same-cycle bus write
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (mode == MODE_PULSE || mode == MODE_STICKY) begin
                        state <= ST_LOAD;
                    end else begin
                        ctrl[CTRL_EN] <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/tc_array.sv
// Multi-channel timer/counter: bus decode, byte-lane merge, W1C status
// register, read mux and interrupt outputs around NUM_CH tc_channel instances.
module tc_array
    import tc_array_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic              we,
    input  logic [3:0]        byteen,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    logic [2:0]        ch_sel;
    logic [1:0]        off_sel;
    logic              is_status;
    logic [NUM_CH-1:0] sel;
    logic [31:0]       be_mask;
    logic              unused_addr;

    logic [CTRL_W-1:0] ctrl_q     [NUM_CH];
    logic [CNT_W-1:0]  preset_q   [NUM_CH];
    logic [CNT_W-1:0]  count_q    [NUM_CH];
    logic [PRE_W-1:0]  prescale_q [NUM_CH];

    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] status_clr;
    logic [NUM_CH-1:0] status;
    logic [NUM_CH-1:0] im;
    logic [NUM_CH-1:0] w1c;

    assign ch_sel      = addr[6:4];
    assign off_sel     = addr[3:2];
    assign is_status   = addr[7] && (addr[6:2] == 5'd0);
    assign be_mask     = byte_mask(byteen);
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i] = !addr[7] && (ch_sel == 3'(i));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CTRL_W-1:0] ctrl_wd;
        logic [CNT_W-1:0]  preset_wd;
        logic [PRE_W-1:0]  prescale_wd;

        assign ctrl_wd     = (ctrl_q[i] & ~be_mask[CTRL_W-1:0])
                           | (wdata[CTRL_W-1:0] & be_mask[CTRL_W-1:0]);
        assign preset_wd   = (preset_q[i] & ~be_mask[CNT_W-1:0])
                           | (wdata[CNT_W-1:0] & be_mask[CNT_W-1:0]);
        assign prescale_wd = (prescale_q[i] & ~be_mask[PRE_W-1:0])
                           | (wdata[PRE_W-1:0] & be_mask[PRE_W-1:0]);
        assign im[i]       = ctrl_q[i][CTRL_IM];

        tc_channel #(
            .CNT_W(CNT_W),
            .PRE_W(PRE_W)
        ) u_ch (
            .clk            (clk),
            .reset          (reset),
            .wr_ctrl        (we && sel[i] && (off_sel == OFF_CTRL)),
            .ctrl_wdata     (ctrl_wd),
            .wr_preset      (we && sel[i] && (off_sel == OFF_PRESET)),
            .preset_wdata   (preset_wd),
            .wr_prescale    (we && sel[i] && (off_sel == OFF_PRESCALE)),
            .prescale_wdata (prescale_wd),
            .ctrl           (ctrl_q[i]),
            .preset         (preset_q[i]),
            .count          (count_q[i]),
            .prescale       (prescale_q[i]),
            .expire         (expire[i]),
            .status_clr     (status_clr[i])
        );
    end

    // Status bits all live in byte lane 0; a same-edge expiry beats the clear
    assign w1c = (we && is_status && byteen[0]) ? wdata[NUM_CH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            status <= '0;
        end else begin
            status <= (status & ~(w1c | status_clr)) | expire;
        end
    end

    assign irq     = status & im;
    assign irq_any = |irq;

    always_comb begin
        rdata = '0;
        if (is_status) begin
            rdata = 32'(status);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel[i]) begin
                    case (off_sel)
                        OFF_CTRL:   rdata = 32'(ctrl_q[i]);
                        OFF_PRESET: rdata = 32'(preset_q[i]);
                        OFF_COUNT:  rdata = 32'(count_q[i]);
                        default:    rdata = 32'(prescale_q[i]);
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tc_array.sv
// Directed and randomized bench for tc_array; expected interrupt timing is
// derived from the start-latency and reload-period formulas.
module tb_tc_array;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we0, we1;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata, rdata1;
    logic [1:0]  irq;
    logic [0:0]  irq1;
    logic        irq_any, irq_any1;

    int cyc;
    int n_tests;
    int n_fail;

    tc_array #(.NUM_CH(2), .CNT_W(32), .PRE_W(8)) u_dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we0), .byteen(byteen),
        .wdata(wdata), .rdata(rdata), .irq(irq), .irq_any(irq_any)
    );

    tc_array #(.NUM_CH(1), .CNT_W(16), .PRE_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .addr(addr), .we(we1), .byteen(byteen),
        .wdata(wdata), .rdata(rdata1), .irq(irq1), .irq_any(irq_any1)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be = 4'hF, input bit to1 = 1'b0);
        addr   = a;
        wdata  = d;
        byteen = be;
        if (to1) we1 = 1'b1;
        else     we0 = 1'b1;
        step();
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a;
        #1;
    endtask

    // Count value after edge t for a channel enabled at edge k
    function automatic int count_at(input int k, input int n, input int p, input int t);
        int c;
        c = n - (t - k - 2) / (p + 1);
        return (c < 0) ? 0 : c;
    endfunction

    task automatic watch(input int ch, input int k, input int n, input int p, input int m,
                         input bit im, input int ncyc, input bit oth);
        int first, per;
        bit st;
        first = k + 3 + (p + 1) * n;
        per   = (p + 1) * n + 3;
        addr  = 32'h80;
        repeat (ncyc) begin
            step();
            if (cyc < first)  st = 1'b0;
            else if (m == 1)  st = ((cyc - first) % per) == 0;
            else              st = 1'b1;
            chk("status", 32'(rdata[ch]), 32'(st));
            chk("irq", 32'(irq[ch]), 32'(st & im));
            chk("irq_other", 32'(irq[1-ch]), 32'(oth));
            chk("irq_any", 32'(irq_any), 32'((st & im) | oth));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int c = 0; c < 2; c++) begin
            for (int o = 0; o < 4; o++) begin
                rd(32'(c * 16 + o * 4));
                chk(tag, rdata, 32'h0);
            end
        end
        rd(32'h80);
        chk(tag, rdata, 32'h0);
        chk(tag, 32'(irq), 32'h0);
        chk(tag, 32'(irq_any), 32'h0);
    endtask

    initial begin
        int k, k2, first, per;
        int ch, n, p, m;
        bit im;
        logic [31:0] a, ctrl_v;

        cyc = 0; n_tests = 0; n_fail = 0;
        reset = 1'b1; addr = '0; we0 = 1'b0; we1 = 1'b0; byteen = 4'hF; wdata = '0;
        step(); step();
        reset = 1'b0;
        chk_all_zero("reset");

        // byte lanes and read-only COUNT
        bus_wr(32'h04, 32'h11223344);
        bus_wr(32'h04, 32'hAABBCCDD, 4'b0010);
        rd(32'h04); chk("byteen_preset", rdata, 32'h1122CC44);
        bus_wr(32'h08, 32'hFFFFFFFF);
        rd(32'h08); chk("count_ro", rdata, 32'h0);
        bus_wr(32'h00, 32'h0000000F, 4'b1110);
        rd(32'h00); chk("byteen_ctrl", rdata, 32'h0);

        // one-shot on ch0
        bus_wr(32'h04, 5);
        bus_wr(32'h0C, 0);
        bus_wr(32'h00, 32'h9); k = cyc;
        watch(0, k, 5, 0, 0, 1'b1, 12, 1'b0);
        rd(32'h00); chk("oneshot_ctrl", rdata, 32'h8);
        rd(32'h08); chk("oneshot_count", rdata, 32'h0);

        // pulse mode on ch1 while ch0 holds its interrupt
        bus_wr(32'h14, 3);
        bus_wr(32'h1C, 1);
        bus_wr(32'h10, 32'hB); k = cyc;
        watch(1, k, 3, 1, 1, 1'b1, 30, 1'b1);
        bus_wr(32'h80, 32'h1);
        chk("w1c_irq0", 32'(irq[0]), 32'h0);
        bus_wr(32'h10, 0);
        step(); step();
        bus_wr(32'h80, 32'h3);

        // sticky mode, W1C racing an expiry
        bus_wr(32'h04, 2);
        bus_wr(32'h0C, 0);
        bus_wr(32'h00, 32'hD); k = cyc;
        first = k + 3 + 2; per = 2 + 3;
        watch(0, k, 2, 0, 2, 1'b1, first - k + 2, 1'b0);
        while (cyc < first + per - 1) step();
        bus_wr(32'h80, 32'h1);
        rd(32'h80); chk("w1c_vs_set", 32'(rdata[0]), 32'h1);
        bus_wr(32'h80, 32'h1);
        rd(32'h80); chk("w1c_clear", 32'(rdata[0]), 32'h0);
        while (cyc < first + 2 * per - 1) step();
        chk("sticky_before", 32'(irq[0]), 32'h0);
        step();
        chk("sticky_reset", 32'(irq[0]), 32'h1);
        bus_wr(32'h00, 0);
        step(); step();
        bus_wr(32'h80, 32'h3);

        // EN cleared mid-count freezes COUNT; re-enable reloads
        bus_wr(32'h04, 10);
        bus_wr(32'h0C, 3);
        bus_wr(32'h00, 32'h1); k = cyc;
        while (cyc < k + 26) step();
        rd(32'h08); chk("count_mid", rdata, 32'(count_at(k, 10, 3, cyc)));
        chk("count_is4", rdata, 32'h4);
        bus_wr(32'h00, 0);
        step(); step(); step(); step();
        rd(32'h08); chk("count_frozen", rdata, 32'h4);
        rd(32'h80); chk("frozen_status", rdata, 32'h0);
        bus_wr(32'h04, 7);
        bus_wr(32'h00, 32'h1); k2 = cyc;
        rd(32'h08); chk("reenable_k", rdata, 32'h4);
        step();
        rd(32'h08); chk("reenable_load", rdata, 32'h4);
        step();
        rd(32'h08); chk("reenable_cnt", rdata, 32'h7);

        // reset while ch0 counts and ch1 has fired (PRESET=0 one-shot)
        bus_wr(32'h14, 0);
        bus_wr(32'h1C, 0);
        bus_wr(32'h10, 32'h9); k = cyc;
        while (cyc < k + 4) step();
        chk("preset0_irq1", 32'(irq[1]), 32'h1);
        reset = 1'b1;
        step();
        chk_all_zero("reset_mid");
        reset = 1'b0;

        // PRESET=0 pulse: 3-cycle period regardless of prescaler
        bus_wr(32'h04, 0);
        bus_wr(32'h0C, 5);
        bus_wr(32'h00, 32'hB); k = cyc;
        watch(0, k, 0, 5, 1, 1'b1, 12, 1'b0);
        bus_wr(32'h00, 0);
        step(); step();
        bus_wr(32'h80, 32'h3);

        // out-of-range channel accesses, 16-bit counter zero-extension
        rd(32'h30); chk("oor_ch3_dut0", rdata, 32'h0);
        bus_wr(32'h30, 32'h9, 4'hF, 1'b1);
        bus_wr(32'h34, 32'h55, 4'hF, 1'b1);
        rd(32'h30); chk("oor_ctrl", rdata1, 32'h0);
        rd(32'h34); chk("oor_preset", rdata1, 32'h0);
        rd(32'h00); chk("dut1_ctrl", rdata1, 32'h0);
        rd(32'h04); chk("dut1_preset", rdata1, 32'h0);
        repeat (6) step();
        chk("dut1_irq", 32'(irq1), 32'h0);
        bus_wr(32'h04, 32'hFFFFFFFF, 4'hF, 1'b1);
        rd(32'h04); chk("dut1_zext", rdata1, 32'h0000FFFF);

        // randomized single-channel runs
        for (int it = 0; it < 12; it++) begin
            ch = int'($urandom_range(0, 1));
            n  = int'($urandom_range(0, 6));
            p  = int'($urandom_range(0, 3));
            m  = int'($urandom_range(0, 3));
            im = 1'($urandom_range(0, 1));
            a  = 32'(ch * 16);
            ctrl_v = 32'((int'(im) << 3) | (m << 1) | 1);
            bus_wr(a + 32'h4, 32'(n));
            bus_wr(a + 32'hC, 32'(p));
            bus_wr(a, ctrl_v); k = cyc;
            watch(ch, k, n, p, m, im, 3 * ((p + 1) * n + 3) + 2, 1'b0);
            rd(a);
            chk("rnd_ctrl", rdata, (m == 1 || m == 2) ? ctrl_v : (ctrl_v & ~32'h1));
            bus_wr(a, 0);
            step(); step();
            bus_wr(32'h80, 32'h3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
